// File: rtl/seq_barrel_shift.sv
// Sequential 8-bit barrel shifter/rotator.
// An operation is decomposed into three conditional stages of 1, 2 and 4
// bit positions, one stage per cycle, so latency is fixed regardless of amt.
//
// Handshake: start is a request that is accepted only on a rising edge where
// busy=0 (state IDLE); while busy=1 start is ignored and nothing is queued.
// done is a one-cycle pulse in the cycle after the final stage, and dout
// holds that result until the next completion.
module seq_barrel_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [2:0] amt,
  input  logic       dir,
  input  logic       rot,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  stage;
  logic [7:0]  work;
  logic [2:0]  amt_r;
  logic        dir_r;
  logic        rot_r;
  logic        stage_en;
  logic [7:0]  work_shifted;

  // Shift or rotate w by 2^s positions (s is 0..2).
  function automatic logic [7:0] stage_op(input logic [7:0] w,
                                          input logic [1:0] s,
                                          input logic       d,
                                          input logic       r);
    logic [3:0]  n;
    logic [15:0] dbl;
    logic [7:0]  res;
    n   = 4'd1 << s;
    dbl = {w, w};
    if (r) begin
      if (d) begin
        dbl = dbl >> n;
        res = dbl[7:0];
      end else begin
        dbl = dbl << n;
        res = dbl[15:8];
      end
    end else begin
      res = d ? (w >> n) : (w << n);
    end
    return res;
  endfunction

  // State register; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, status outputs and the per-stage shift decision.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    stage_en     = 1'b0;
    work_shifted = work;
    case (stage)
      2'd0:    stage_en = amt_r[0];
      2'd1:    stage_en = amt_r[1];
      default: stage_en = amt_r[2];
    endcase
    if (stage_en) begin
      work_shifted = stage_op(work, stage, dir_r, rot_r);
    end
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (stage == 2'd2) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, one stage per SHIFT cycle, publish on last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage <= 2'd0;
      work  <= 8'h00;
      dout  <= 8'h00;
      amt_r <= 3'd0;
      dir_r <= 1'b0;
      rot_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= din;
            amt_r <= amt;
            dir_r <= dir;
            rot_r <= rot;
            stage <= 2'd0;
          end
        end
        SHIFT: begin
          work <= work_shifted;
          if (stage == 2'd2) begin
            dout  <= work_shifted;
            stage <= 2'd0;
          end else begin
            stage <= stage + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
